instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction ROM.
- Owns the PC register and drives the byte address into the combinational instruction memory.
- Captures each returned instruction with its PC into a small FIFO and presents it to decode through a valid/ready handshake.
- Accepts branch/jump redirects from execute, which flush the buffer and reload the PC.

---
 rtl/instruction_fetch_unit.sv | 140 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage sitting directly in front of a
// combinational instruction ROM. It owns the PC and drives it out as the ROM
// byte address. Each returned word is captured with its PC in a small FIFO
// and presented to decode. Redirects from execute flush the FIFO and reload
// the PC.
//
// Optional build macro: FETCH_ALIGN_CHECK_EN
//   undefined : redirect target bits [1:0] are silently cleared and
//               FetchFault is tied low.
//   defined   : a misaligned redirect loads the PC unmodified and sets a
//               sticky FetchFault. It also sets a halt that stops all
//               further fetches until reset.
//
// Handshake (decode side): OutValid/OutReady follow strict valid/ready rules.
// OutValid never depends on OutReady. The head entry is consumed on a rising
// edge where both are high. OutPc/OutInstruction are only meaningful while
// OutValid is high. A redirect forces OutValid low in its own cycle, so a
// flushed entry can never be consumed.
//
// RESET_PC must be 4-byte aligned.
// BUF_DEPTH must be a power of two and at least 2.

module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ImemAddress,
  input  logic [31:0] ImemInstruction,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  output logic        OutValid,
  input  logic        OutReady,
  output logic [31:0] OutPc,
  output logic [31:0] OutInstruction,
  output logic        FetchFault
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  // Architectural fetch state
  logic [31:0]      pc_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Fetch buffer storage; contents are only meaningful below count_q
  logic [31:0] buf_pc    [BUF_DEPTH];
  logic [31:0] buf_instr [BUF_DEPTH];

  // Control
  logic        halted;
  logic [31:0] redirect_pc;
  logic        push;
  logic        pop;
  logic        buf_has_room;

`ifdef FETCH_ALIGN_CHECK_EN
  logic halted_q;
  logic fault_q;

  // Sticky fault/halt on a misaligned redirect; only reset clears them
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
    end else if (RedirectValid && (RedirectTarget[1:0] != 2'b00)) begin
      halted_q <= 1'b1;
      fault_q  <= 1'b1;
    end
  end

  assign halted      = halted_q;
  assign FetchFault  = fault_q;
  // The target is taken as given; a misaligned one has already raised the fault
  assign redirect_pc = RedirectTarget;
`else
  logic unused_target_lsbs;

  assign halted             = 1'b0;
  assign FetchFault         = 1'b0;
  // Instructions are word aligned, so the low target bits are dropped
  assign redirect_pc        = {RedirectTarget[31:2], 2'b00};
  assign unused_target_lsbs = ^RedirectTarget[1:0];
`endif

  // The PC register is the ROM address; the ROM answers in the same cycle
  assign ImemAddress = pc_q;

  // Head of buffer toward decode; a redirect or halt hides any entry
  assign OutValid       = (count_q != '0) && !RedirectValid && !halted;
  assign OutPc          = buf_pc[rd_ptr_q];
  assign OutInstruction = buf_instr[rd_ptr_q];

  // A full buffer can take a new word in the same cycle as a pop
  assign pop          = OutValid && OutReady;
  assign buf_has_room = (count_q < DEPTH_C) || pop;
  assign push         = !RedirectValid && !halted && buf_has_room;

  // PC, occupancy and pointers; reset outranks a redirect, which outranks push/pop
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (RedirectValid) begin
      pc_q     <= redirect_pc;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        pc_q     <= pc_q + 32'd4;
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  // Capture the fetched word with its PC; a write during reset is harmless
  // because the count is cleared in the same cycle
  always_ff @(posedge clk) begin
    if (push) begin
      buf_pc[wr_ptr_q]    <= pc_q;
      buf_instr[wr_ptr_q] <= ImemInstruction;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: two instances, one with RESET_PC=0 driven
// from a cycle table, one with RESET_PC=FFFF_FFF8 for wrap and random traffic.
module tb_instruction_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: a fixed scramble of the address
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- DUT 0 (RESET_PC = 0) ----------------
  logic        rst0_n, redir0, rdy0;
  logic [31:0] tgt0, addr0, instr0, opc0, oinstr0;
  logic        oval0, fault0;
  assign instr0 = rom_word(addr0);

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut0 (
    .clk(clk), .rst_n(rst0_n), .ImemAddress(addr0), .ImemInstruction(instr0),
    .RedirectValid(redir0), .RedirectTarget(tgt0), .OutValid(oval0),
    .OutReady(rdy0), .OutPc(opc0), .OutInstruction(oinstr0), .FetchFault(fault0)
  );

  // ---------------- DUT 1 (RESET_PC = FFFF_FFF8) ----------------
  logic        rst1_n, redir1, rdy1;
  logic [31:0] tgt1, addr1, instr1, opc1, oinstr1;
  logic        oval1, fault1;
  assign instr1 = rom_word(addr1);

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .rst_n(rst1_n), .ImemAddress(addr1), .ImemInstruction(instr1),
    .RedirectValid(redir1), .RedirectTarget(tgt1), .OutValid(oval1),
    .OutReady(rdy1), .OutPc(opc1), .OutInstruction(oinstr1), .FetchFault(fault1)
  );

  // ---------------- counters / checks ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // ---------------- cycle table for DUT 0 ----------------
  typedef struct {
    logic        rst_n;
    logic        redir;
    logic        rdy;
    logic [31:0] tgt;
    logic        chk;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic        chk_pc;
    logic [31:0] exp_pc;
    logic        exp_fault;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rst_n, input logic redir, input logic rdy, input logic [31:0] tgt,
                     input logic chk, input logic [31:0] ea, input logic ev,
                     input logic cp, input logic [31:0] ep, input logic ef);
    vec_t v;
    v.rst_n = rst_n; v.redir = redir; v.rdy = rdy; v.tgt = tgt;
    v.chk = chk; v.exp_addr = ea; v.exp_valid = ev;
    v.chk_pc = cp; v.exp_pc = ep; v.exp_fault = ef;
    vq.push_back(v);
  endtask

  task automatic fill_table();
    //  rst redir rdy target        chk addr          valid chkpc pc            fault
    add(0, 0, 0, 32'h0,          0, 32'h0,        0, 0, 32'h0,        0);
    add(0, 0, 1, 32'h0,          1, 32'h0,        0, 0, 32'h0,        0);
    // free run from reset
    add(1, 0, 1, 32'h0,          1, 32'h0,        0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h4,        1, 1, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h8,        1, 1, 32'h4,        0);
    add(1, 0, 1, 32'h0,          1, 32'hC,        1, 1, 32'h8,        0);
    add(1, 0, 1, 32'h0,          1, 32'h10,       1, 1, 32'hC,        0);
    // stall from reset: buffer fills, PC holds at 8
    add(0, 0, 0, 32'h0,          1, 32'h14,       1, 1, 32'h10,       0);
    add(1, 0, 0, 32'h0,          1, 32'h0,        0, 0, 32'h0,        0);
    add(1, 0, 0, 32'h0,          1, 32'h4,        1, 1, 32'h0,        0);
    add(1, 0, 0, 32'h0,          1, 32'h8,        1, 1, 32'h0,        0);
    add(1, 0, 0, 32'h0,          1, 32'h8,        1, 1, 32'h0,        0);
    // drain with same-cycle refill
    add(1, 0, 1, 32'h0,          1, 32'h8,        1, 1, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'hC,        1, 1, 32'h4,        0);
    // redirect with two buffered entries
    add(1, 1, 1, 32'h100,        1, 32'h10,       0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h100,      0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h104,      1, 1, 32'h100,      0);
    // misaligned redirect
    add(1, 1, 1, 32'h42,         1, 32'h108,      0, 0, 32'h0,        0);
`ifdef FETCH_ALIGN_CHECK_EN
    add(1, 0, 1, 32'h0,          1, 32'h42,       0, 0, 32'h0,        1);
    add(1, 0, 1, 32'h0,          1, 32'h42,       0, 0, 32'h0,        1);
    add(1, 1, 1, 32'h80,         1, 32'h42,       0, 0, 32'h0,        1);
    add(1, 0, 1, 32'h0,          1, 32'h80,       0, 0, 32'h0,        1);
    add(1, 0, 1, 32'h0,          1, 32'h80,       0, 0, 32'h0,        1);
    add(0, 0, 1, 32'h0,          1, 32'h80,       0, 0, 32'h0,        1);
`else
    add(1, 0, 1, 32'h0,          1, 32'h40,       0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h44,       1, 1, 32'h40,       0);
    add(1, 1, 1, 32'h80,         1, 32'h48,       0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h80,       0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h84,       1, 1, 32'h80,       0);
    add(0, 0, 1, 32'h0,          1, 32'h88,       1, 1, 32'h84,       0);
`endif
    // after reset: fault cleared, PC back at 0
    add(1, 0, 1, 32'h0,          1, 32'h0,        0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h4,        1, 1, 32'h0,        0);
    // back-to-back redirects: last one wins
    add(1, 1, 1, 32'h200,        1, 32'h8,        0, 0, 32'h0,        0);
    add(1, 1, 1, 32'h300,        1, 32'h200,      0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h300,      0, 0, 32'h0,        0);
    add(1, 0, 1, 32'h0,          1, 32'h304,      1, 1, 32'h300,      0);
  endtask

  // ---------------- scoreboard for DUT 1 ----------------
  logic [63:0] exp_q[$];
  logic [31:0] tail_pc;
  int          pops;

  task automatic sb_refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back({tail_pc, rom_word(tail_pc)});
      tail_pc = tail_pc + 32'd4;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] wrap_pc [4];
    logic [63:0] e;

    rst0_n = 1'b0; redir0 = 1'b0; rdy0 = 1'b0; tgt0 = '0;
    rst1_n = 1'b0; redir1 = 1'b0; rdy1 = 1'b0; tgt1 = '0;
    pops = 0;

    // table-driven cycles on DUT 0
    fill_table();
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst0_n = vq[i].rst_n; redir0 = vq[i].redir; rdy0 = vq[i].rdy; tgt0 = vq[i].tgt;
      #1;
      if (vq[i].chk) begin
        check32($sformatf("row%0d ImemAddress", i), addr0, vq[i].exp_addr);
        check1($sformatf("row%0d OutValid", i), oval0, vq[i].exp_valid);
        check1($sformatf("row%0d FetchFault", i), fault0, vq[i].exp_fault);
      end
      if (vq[i].chk_pc) begin
        check32($sformatf("row%0d OutPc", i), opc0, vq[i].exp_pc);
        check32($sformatf("row%0d OutInstruction", i), oinstr0, rom_word(vq[i].exp_pc));
      end
    end

    // hand sequence: PC wrap through 2^32 on DUT 1
    wrap_pc[0] = 32'hFFFF_FFF8; wrap_pc[1] = 32'hFFFF_FFFC;
    wrap_pc[2] = 32'h0000_0000; wrap_pc[3] = 32'h0000_0004;
    @(negedge clk); rst1_n = 1'b0; rdy1 = 1'b1;
    @(negedge clk); rst1_n = 1'b1;
    #1;
    check32("wrap reset addr", addr1, 32'hFFFF_FFF8);
    check1("wrap reset valid", oval1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      check1($sformatf("wrap%0d valid", k), oval1, 1'b1);
      check32($sformatf("wrap%0d OutPc", k), opc1, wrap_pc[k]);
      check32($sformatf("wrap%0d OutInstruction", k), oinstr1, rom_word(wrap_pc[k]));
    end

    // random traffic on DUT 1 with scoreboard
    @(negedge clk); rst1_n = 1'b0;
    @(negedge clk); rst1_n = 1'b1;
    exp_q.delete();
    tail_pc = 32'hFFFF_FFF8;
    sb_refill();
    for (int c = 0; c < 400; c++) begin
      if (c != 0) @(negedge clk);
      redir1 = ($urandom_range(0, 15) == 0);
      tgt1   = $urandom & 32'hFFFF_FFFC;
      rdy1   = ($urandom_range(0, 3) != 0);
      if (redir1) begin
        exp_q.delete();
        tail_pc = tgt1;
      end
      sb_refill();
      #1;
      if (oval1 && rdy1) begin
        e = exp_q.pop_front();
        check32($sformatf("sb%0d OutPc", c), opc1, e[63:32]);
        check32($sformatf("sb%0d OutInstruction", c), oinstr1, e[31:0]);
        pops++;
      end
    end
    @(negedge clk); redir1 = 1'b0; rdy1 = 1'b0;
    check1("sb progress", (pops > 100), 1'b1);
    check1("sb FetchFault", fault1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
